// File: rtl/multiplication_shift_add_pkg.sv
// Shared constants, state encoding and helpers for the fixed-point
// shift-add multiplier (encoding is common with the divider).
package multiplication_shift_add_pkg;

    localparam int N          = 16;
    localparam int SCALE_W    = 3;
    localparam int OUT_SCALE  = 3;
    localparam int MANT_W     = N - SCALE_W;
    localparam int ITERATIONS = 13;
    localparam int SUM_W      = SCALE_W + 1;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_e;

    // The most negative mantissa maps to 2^(MANT_W-1), which still fits unsigned.
    function automatic logic [MANT_W-1:0] magnitude(input logic [MANT_W-1:0] m);
        return m[MANT_W-1] ? -m : m;
    endfunction

endpackage

// File: rtl/multiplication_shift_add_if.sv
// Request/result bundle between a requester and the shift-add multiplier.
interface multiplication_shift_add_if;
    import multiplication_shift_add_pkg::*;

    logic         start;
    logic [N-1:0] multiplicand;
    logic [N-1:0] multiplier;
    logic [N-1:0] product;
    logic         busy;
    logic         ready;
    logic         overflow;

    modport master (
        output start, multiplicand, multiplier,
        input  product, busy, ready, overflow
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output product, busy, ready, overflow
    );

endinterface

// File: rtl/carry_lookahead_adder_16bit.sv
// 16-bit two-level carry-lookahead adder: 4-bit groups with lookahead
// across the group generate/propagate terms.
module carry_lookahead_adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  bg;
    logic [3:0]  bp;
    logic [4:0]  bc;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            bg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            bp[k] = &p[4*k +: 4];
        end
    end

    assign bc[0] = cin;
    assign bc[1] = bg[0] | (bp[0] & cin);
    assign bc[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & cin);
    assign bc[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                 | (bp[2] & bp[1] & bp[0] & cin);
    assign bc[4] = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
                 | (bp[3] & bp[2] & bp[1] & bg[0])
                 | (bp[3] & bp[2] & bp[1] & bp[0] & cin);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = bc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & bc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
        end
    end

    assign sum  = p ^ c;
    assign cout = bc[4];

endmodule

// File: rtl/multiplication_shift_add.sv
// Sign-magnitude shift-add multiplier for scaled fixed-point words; the
// product is renormalised to a fixed output scale with overflow detection.
module multiplication_shift_add #(
    parameter int N         = multiplication_shift_add_pkg::N,
    parameter int SCALE_W   = multiplication_shift_add_pkg::SCALE_W,
    parameter int OUT_SCALE = multiplication_shift_add_pkg::OUT_SCALE
) (
    input  logic                       clk,
    input  logic                       reset,
    multiplication_shift_add_if.slave  bus
);
    import multiplication_shift_add_pkg::*;

    localparam int MW     = N - SCALE_W;
    localparam int ACC_W  = 2 * MW;
    localparam int NORM_W = ACC_W + (2 ** SCALE_W) - 1;
    localparam logic [SUM_W-1:0] OUT_S = SUM_W'(OUT_SCALE);

    state_e            state;
    state_e            next_state;
    logic              accept;
    logic              step;
    logic              finish;

    logic [MW-1:0]     mag_a;
    logic [MW-1:0]     mag_b;
    logic              sign;
    logic [SUM_W-1:0]  scale_sum;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  count;
    logic [N-1:0]      product;
    logic              ready;
    logic              overflow;

    logic [MW-1:0]     mant_a;
    logic [MW-1:0]     mant_b;
    logic [SCALE_W-1:0] scale_a;
    logic [SCALE_W-1:0] scale_b;

    logic [15:0]       add_a;
    logic [15:0]       add_b;
    logic [15:0]       add_sum;
    logic              add_cout;
    logic              unused_add;

    logic [NORM_W-1:0] norm_wide;
    logic              norm_ovf;
    logic [MW-1:0]     norm_mant;

    assign mant_a  = bus.multiplicand[MW-1:0];
    assign mant_b  = bus.multiplier[MW-1:0];
    assign scale_a = bus.multiplicand[N-1:MW];
    assign scale_b = bus.multiplier[N-1:MW];

    // Partial product: the multiplier LSB gates |mA| into the upper accumulator half.
    assign add_a = 16'(acc[ACC_W-1:MW]);
    assign add_b = 16'(mag_b[0] ? mag_a : '0);

    carry_lookahead_adder_16bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign unused_add = &{1'b0, add_sum[15:MW+1], add_cout};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = MULT;
                end
            end
            MULT: begin
                step = 1'b1;
                if (count == CNT_W'(ITERATIONS - 1)) next_state = NORM;
            end
            NORM: begin
                finish     = 1'b1;
                next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Rescale the raw magnitude from scale S to OUT_SCALE; right shifts truncate.
    always_comb begin
        norm_wide = '0;
        if (scale_sum >= OUT_S)
            norm_wide = NORM_W'(acc) >> (scale_sum - OUT_S);
        else
            norm_wide = NORM_W'(acc) << (OUT_S - scale_sum);
    end

    assign norm_ovf  = |norm_wide[NORM_W-1:MW-1];
    assign norm_mant = sign ? -norm_wide[MW-1:0] : norm_wide[MW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            mag_a     <= '0;
            mag_b     <= '0;
            sign      <= 1'b0;
            scale_sum <= '0;
            acc       <= '0;
            count     <= '0;
            product   <= '0;
            ready     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                mag_a     <= magnitude(mant_a);
                mag_b     <= magnitude(mant_b);
                sign      <= mant_a[MW-1] ^ mant_b[MW-1];
                scale_sum <= SUM_W'(scale_a) + SUM_W'(scale_b);
                acc       <= '0;
                count     <= '0;
                ready     <= 1'b0;
                overflow  <= 1'b0;
            end
            if (step) begin
                acc   <= {add_sum[MW:0], acc[MW-1:1]};
                mag_b <= mag_b >> 1;
                count <= count + 1'b1;
            end
            if (finish) begin
                product  <= norm_ovf ? '0 : {SCALE_W'(OUT_SCALE), norm_mant};
                overflow <= norm_ovf;
                ready    <= 1'b1;
            end
        end
    end

    assign bus.product  = product;
    assign bus.ready    = ready;
    assign bus.overflow = overflow;
    assign bus.busy     = (state == MULT) || (state == NORM);

endmodule

// File: tb/tb_multiplication_shift_add.sv
// Directed self-checking bench for multiplication_shift_add.
module tb_multiplication_shift_add;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    multiplication_shift_add_if bus ();

    multiplication_shift_add dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Starts one operation and waits (bounded) for ready; optionally pulses
    // start with junk operands on edges 3 and 10 while busy.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_product, input logic exp_ovf,
                          input bit noise);
        int lat;
        @(negedge clk);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.start        = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
        check({tag, "_ready_dropped"}, 32'(bus.ready), 32'd0);
        lat = 0;
        while (!bus.ready && lat < 40) begin
            if (noise && (lat == 2 || lat == 9)) begin
                bus.start        = 1'b1;
                bus.multiplicand = 16'h03E8;
                bus.multiplier   = 16'h03E8;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd14);
        check({tag, "_product"}, 32'(bus.product), 32'(exp_product));
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = 16'h0000;
        bus.multiplier   = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_product", 32'(bus.product), 32'd0);
        check("reset_ready", 32'(bus.ready), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_overflow", 32'(bus.overflow), 32'd0);

        // Basic arithmetic, including sign handling and both shift directions.
        run_op("pos_1p5_x_2", 16'h600C, 16'h2004, 16'h6018, 1'b0, 1'b0);
        run_op("neg_1p5_x_2", 16'h7FF4, 16'h2004, 16'h7FE8, 1'b0, 1'b0);
        run_op("left_shift", 16'h0003, 16'h0005, 16'h6078, 1'b0, 1'b0);
        run_op("truncate", 16'h6001, 16'h6001, 16'h6000, 1'b0, 1'b0);
        run_op("neg_x_neg", 16'h3FFC, 16'h7FF4, 16'h6018, 1'b0, 1'b0);
        run_op("most_neg", 16'h7000, 16'h6001, 16'h7E00, 1'b0, 1'b0);
        run_op("neg_zero", 16'h7FFF, 16'h6001, 16'h6000, 1'b0, 1'b0);
        run_op("max_fit", 16'h01FF, 16'h0001, 16'h6FF8, 1'b0, 1'b0);
        run_op("min_ovf", 16'h0200, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run_op("big_ovf", 16'h03E8, 16'h03E8, 16'h0000, 1'b1, 1'b0);
        check("big_ovf_ready", 32'(bus.ready), 32'd1);

        // Starts while busy are ignored.
        run_op("busy_ignore", 16'h600C, 16'h2004, 16'h6018, 1'b0, 1'b1);

        // Results hold in DONE while operands wander without a start.
        @(negedge clk);
        bus.multiplicand = 16'h1234;
        bus.multiplier   = 16'h4321;
        repeat (3) @(posedge clk);
        #1;
        check("hold_product", 32'(bus.product), 32'h6018);
        check("hold_ready", 32'(bus.ready), 32'd1);
        check("hold_busy", 32'(bus.busy), 32'd0);

        // Back-to-back: start right after completion.
        run_op("b2b_first", 16'h2004, 16'h2004, 16'h6020, 1'b0, 1'b0);
        run_op("b2b_second", 16'h7FF4, 16'h2004, 16'h7FE8, 1'b0, 1'b0);

        // Reset in MULT cycle 7 aborts everything.
        @(negedge clk);
        bus.multiplicand = 16'h600C;
        bus.multiplier   = 16'h2004;
        bus.start        = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_reset_product", 32'(bus.product), 32'd0);
        check("mid_reset_ready", 32'(bus.ready), 32'd0);
        check("mid_reset_busy", 32'(bus.busy), 32'd0);
        check("mid_reset_overflow", 32'(bus.overflow), 32'd0);
        run_op("after_reset", 16'h2004, 16'h2004, 16'h6020, 1'b0, 1'b0);

        // Reset beats a simultaneous start.
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        check("reset_vs_start_busy", 32'(bus.busy), 32'd0);
        check("reset_vs_start_ready", 32'(bus.ready), 32'd0);
        @(posedge clk);
        #1;
        check("reset_vs_start_idle", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplication_shift_add.md
MULTIPLICATION_SHIFT_ADD -- requirements
Module: multiplication_shift_add

Interface
REQ-001 Parameter N, 16, total word width of operands and result.
REQ-002 Parameter SCALE_W, 3, width of the scale-factor field in bits [N-1:N-SCALE_W].
REQ-003 Parameter OUT_SCALE, 3, scale factor written into every result.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-007 multiplicand  input  16  operand A: [15:13] scale s_a (fractional bits), [12:0] two's-complement mantissa.
REQ-008 multiplier  input  16  operand B, same format as multiplicand.
REQ-009 product  output  16  result: [15:13] = OUT_SCALE, [12:0] = two's-complement mantissa.
REQ-010 busy  output  1  high while an operation is in progress (MULT or NORM).
REQ-011 ready  output  1  high from result registration until the next accepted start or reset.
REQ-012 overflow  output  1  valid with ready; high when the result mantissa does not fit.

Function
REQ-013 Value of an operand SHALL be mantissa / 2^s; product value SHALL be A*B expressed at scale OUT_SCALE.
REQ-014 FSM SHALL have states IDLE, MULT, NORM, DONE.
REQ-015 IDLE/DONE + start=1: latch operands, sign = sign(A) xor sign(B), 13-bit magnitudes |mA|, |mB|, scale sum S = s_a + s_b (4 bits, 0..14), clear 26-bit accumulator, drop ready and overflow, go to MULT.
REQ-016 MULT SHALL perform one shift-add step per cycle (LSB of |mB| gates addition of |mA| into upper accumulator half, then shift right) for exactly 13 cycles, then go to NORM.
REQ-017 NORM, one cycle: if S >= 3 shift magnitude right by S-3 (truncate toward zero), else shift left by 3-S; then register product, ready=1, go to DONE.
REQ-018 Overflow SHALL be set when normalized magnitude >= 4096; then product = 16'h0000.
REQ-019 Otherwise product[12:0] SHALL be the magnitude negated when sign=1; product[15:13] = OUT_SCALE; zero results never negative.
REQ-020 Latency: start sampled on edge 0 -> ready, product, overflow valid after edge 14; busy high after edges 1..14 exclusive of edge 14 (i.e. visible during cycles 1..14).
REQ-021 start while busy SHALL be ignored; operands, product, ready unaffected.
REQ-022 start in DONE SHALL begin a new operation on the same edge (back-to-back throughput 15 cycles).
REQ-023 product, overflow SHALL hold their value in DONE until the next accepted start.
REQ-024 Operand changes outside the accepting edge SHALL have no effect.

Reset
REQ-025 reset=1 SHALL force IDLE, product=0, ready=0, busy=0, overflow=0, accumulator and counter cleared, on the next edge, including mid-MULT or mid-NORM.
REQ-026 reset SHALL take priority over simultaneous start.

Structure
REQ-027 Shared package SHALL hold N, SCALE_W, OUT_SCALE, mantissa width (13), iteration count (13) and the state encoding, common with the divider.
REQ-028 The accumulate step SHALL instantiate the existing carry_lookahead_adder_16bit as the single sub-module; no other sub-modules.

Verification
REQ-029 0x600C (1.5) x 0x2004 (2.0) -> product 0x6018 (3.0), overflow 0, ready after edge 14.
REQ-030 0x7FF4 (-1.5) x 0x2004 -> product 0x7FE8 (-3.0), overflow 0.
REQ-031 0x0003 x 0x0005 (S=0, left shift) -> product 0x6078 (15.0); 0x6001 x 0x6001 -> 0x6000 (truncated), overflow 0.
REQ-032 0x03E8 x 0x03E8 -> overflow 1, product 0x0000, ready 1.
REQ-033 start pulses during cycles 3 and 10 of an operation -> ignored, result identical to REQ-029; start in DONE -> new result 15 cycles later.
REQ-034 reset asserted in MULT cycle 7 -> next cycle all outputs 0, state IDLE; subsequent start completes normally.
